sorter_arbiter: RTL

- Shares one sorter_stack instance among N_CH packet producers.
- Takes N_CH Avalon-ST-style packet streams (valid/ready/sop/eop/data) and grants the sorter sink to one channel per whole packet, in round-robin order.
- Enforces the sorter's MAX_LENGTH by truncating long packets, and discards orphan words that arrive outside a packet.
- Sits on the sorter's sink clock domain, directly in front of sorter_stack's snk_* ports.

---
 rtl/sorter_pkg.sv | 17 +
 rtl/sorter_arbiter_if.sv | 30 +++
 rtl/sorter_arbiter_rr_picker.sv | 32 +++
 rtl/sorter_arbiter.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/sorter_pkg.sv
// Shared types and defaults for the sorter front end (sorter_stack and sorter_arbiter).
package sorter_pkg;

  localparam int SORTER_DATA_WIDTH = 16;
  localparam int SORTER_MAX_LENGTH = 30;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PASS = 2'd1,
    DROP = 2'd2
  } state_t;

  function automatic int ch_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sorter_arbiter_if.sv
// Bundle of N_CH producer streams plus the single stream into the sorter sink.
interface sorter_arbiter_if
  import sorter_pkg::*;
#(
  parameter int N_CH       = 4,
  parameter int DATA_WIDTH = SORTER_DATA_WIDTH,
  parameter int CH_W       = ch_w(N_CH)
);
  logic [N_CH-1:0]            in_valid;
  logic [N_CH-1:0]            in_sop;
  logic [N_CH-1:0]            in_eop;
  logic [N_CH*DATA_WIDTH-1:0] in_data;
  logic [N_CH-1:0]            in_ready;
  logic                       out_valid;
  logic                       out_sop;
  logic                       out_eop;
  logic [DATA_WIDTH-1:0]      out_data;
  logic [CH_W-1:0]            out_channel;
  logic                       out_ready;

  modport slave (
    input  in_valid, in_sop, in_eop, in_data, out_ready,
    output in_ready, out_valid, out_sop, out_eop, out_data, out_channel
  );

  modport master (
    output in_valid, in_sop, in_eop, in_data, out_ready,
    input  in_ready, out_valid, out_sop, out_eop, out_data, out_channel
  );
endinterface

// File: rtl/sorter_arbiter_rr_picker.sv
// Rotate-priority encoder: first requester at or after ptr, searching upward modulo N_CH.
module rr_picker
  import sorter_pkg::*;
#(
  parameter int N_CH = 4,
  parameter int CH_W = ch_w(N_CH)
) (
  input  logic [N_CH-1:0] req,
  input  logic [CH_W-1:0] ptr,
  output logic [CH_W-1:0] gnt_idx,
  output logic            any
);

  logic [N_CH-1:0] w_rot;

  // Bit i of w_rot is the request of channel (ptr + i) mod N_CH.
  assign w_rot = N_CH'({req, req} >> ptr);
  assign any   = |w_rot;

  always_comb begin
    int w_off;
    int w_sum;
    w_off = 0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (w_rot[i]) w_off = i;
    end
    w_sum = int'(ptr) + w_off;
    if (w_sum >= N_CH) w_sum = w_sum - N_CH;
    gnt_idx = CH_W'(w_sum);
  end

endmodule

// File: rtl/sorter_arbiter.sv
// Round-robin packet arbiter feeding one sorter_stack sink; truncates long packets
// and discards words that arrive outside a packet.
module sorter_arbiter
  import sorter_pkg::*;
#(
  parameter int DATA_WIDTH = SORTER_DATA_WIDTH,
  parameter int MAX_LENGTH = SORTER_MAX_LENGTH,
  parameter int N_CH       = 4,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  sorter_arbiter_if.slave      bus,
  output logic                 busy,
  output logic [CNT_WIDTH-1:0] trunc_count,
  output logic [CNT_WIDTH-1:0] drop_count
);

  localparam int CH_W  = ch_w(N_CH);
  localparam int INC_W = $clog2(N_CH + 2);

  function automatic logic [CNT_WIDTH-1:0] sat_add(input logic [CNT_WIDTH-1:0] a,
                                                   input logic [INC_W-1:0]     b);
    logic [CNT_WIDTH:0] s;
    s = {1'b0, a} + (CNT_WIDTH + 1)'(b);
    return s[CNT_WIDTH] ? '1 : s[CNT_WIDTH-1:0];
  endfunction

  state_t                 r_state, w_state_nxt;
  logic [CH_W-1:0]        r_gnt, w_gnt_nxt;
  logic [CH_W-1:0]        r_ptr, w_ptr_nxt;
  logic [5:0]             r_wcnt, w_wcnt_nxt;
  logic [CNT_WIDTH-1:0]   r_trunc, r_drop;

  logic                   r_vld_p1, r_sop_p1, r_eop_p1;
  logic [DATA_WIDTH-1:0]  r_data_p1;
  logic [CH_W-1:0]        r_ch_p1;

  logic                   w_load, w_acc, w_cap, w_trunc_inc;
  logic                   w_g_valid, w_g_eop, w_pick_any;
  logic [CH_W-1:0]        w_pick;
  logic [N_CH-1:0]        w_sop_req, w_orphan, w_one_hot, w_ready;
  logic [INC_W-1:0]       w_drop_inc;
  logic [DATA_WIDTH-1:0]  w_g_data;

  assign w_load    = !r_vld_p1 || bus.out_ready;
  assign w_sop_req = bus.in_valid & bus.in_sop;
  assign w_orphan  = bus.in_valid & ~bus.in_sop;
  assign w_one_hot = {{(N_CH-1){1'b0}}, 1'b1} << r_gnt;
  assign w_g_valid = |(bus.in_valid & w_one_hot);
  assign w_g_eop   = |(bus.in_eop & w_one_hot);
  assign w_g_data  = DATA_WIDTH'(bus.in_data >> (int'(r_gnt) * DATA_WIDTH));
  assign w_cap     = (r_wcnt == 6'(MAX_LENGTH - 1));

  rr_picker #(.N_CH(N_CH), .CH_W(CH_W)) u_picker (
    .req     (w_sop_req),
    .ptr     (r_ptr),
    .gnt_idx (w_pick),
    .any     (w_pick_any)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_gnt_nxt   = r_gnt;
    w_ptr_nxt   = r_ptr;
    w_wcnt_nxt  = r_wcnt;
    w_ready     = '0;
    w_acc       = 1'b0;
    w_drop_inc  = '0;
    w_trunc_inc = 1'b0;
    case (r_state)
      IDLE: begin
        // The winning sop word stays on its channel and is taken in PASS.
        w_ready    = w_orphan;
        w_drop_inc = INC_W'($countones(w_orphan));
        if (w_pick_any) begin
          w_gnt_nxt   = w_pick;
          w_ptr_nxt   = (int'(w_pick) == N_CH - 1) ? '0 : w_pick + CH_W'(1);
          w_wcnt_nxt  = '0;
          w_state_nxt = PASS;
        end
      end
      PASS: begin
        if (w_load) w_ready = w_one_hot;
        if (w_load && w_g_valid) begin
          w_acc      = 1'b1;
          w_wcnt_nxt = r_wcnt + 6'd1;
          if (w_g_eop) begin
            w_state_nxt = IDLE;
          end else if (w_cap) begin
            w_trunc_inc = 1'b1;
            w_state_nxt = DROP;
          end
        end
      end
      DROP: begin
        w_ready = w_one_hot;
        if (w_g_valid) begin
          w_drop_inc = INC_W'(1);
          if (w_g_eop) w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_gnt   <= '0;
      r_ptr   <= '0;
      r_wcnt  <= '0;
      r_trunc <= '0;
      r_drop  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_gnt   <= w_gnt_nxt;
      r_ptr   <= w_ptr_nxt;
      r_wcnt  <= w_wcnt_nxt;
      if (w_trunc_inc) r_trunc <= sat_add(r_trunc, INC_W'(1));
      if (|w_drop_inc) r_drop <= sat_add(r_drop, w_drop_inc);
    end
  end

  // Stage p1: output register, reloads whenever empty or being drained.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_vld_p1  <= 1'b0;
      r_sop_p1  <= 1'b0;
      r_eop_p1  <= 1'b0;
      r_data_p1 <= '0;
      r_ch_p1   <= '0;
    end else if (w_load) begin
      r_vld_p1 <= w_acc;
      if (w_acc) begin
        r_sop_p1  <= (r_wcnt == 6'd0);
        r_eop_p1  <= w_g_eop || w_cap;
        r_data_p1 <= w_g_data;
        r_ch_p1   <= r_gnt;
      end
    end
  end

  assign bus.in_ready    = w_ready & ~{N_CH{reset}};
  assign bus.out_valid   = r_vld_p1;
  assign bus.out_sop     = r_sop_p1;
  assign bus.out_eop     = r_eop_p1;
  assign bus.out_data    = r_data_p1;
  assign bus.out_channel = r_ch_p1;
  assign busy            = (r_state != IDLE);
  assign trunc_count     = r_trunc;
  assign drop_count      = r_drop;

endmodule
